// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: core word widths,
// memory map base, FSM state encoding and the word returned on a fault.
package inst_fetch_responder_pkg;

    localparam int InstWidth = 32;
    localparam int PcWidth   = 32;
    localparam int ImmWidth  = 32;

    // Byte address that maps onto word 0 of the instruction array
    localparam logic [31:0] MemBase = 32'h80000000;

    // Instruction word handed back when a fetch faults
    localparam logic [31:0] FaultInst = 32'h0;

    // Widest latency count the responder supports (LATENCY is 1..15)
    localparam int LatCountWidth = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } FetchState;

    // Counter value loaded when a request is accepted
    function automatic logic [LatCountWidth-1:0] latencyLoad(input int latency);
        return LatCountWidth'(latency - 1);
    endfunction

endpackage

// File: rtl/inst_fetch_responder_mem.sv
// Instruction storage: one synchronous write port for preloading and one
// combinational read port. The parent registers the read word when a
// response is formed, so a same-edge write is never seen by that read.
module inst_mem_array
    import inst_fetch_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int INST_WIDTH = InstWidth
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [DEPTH_LOG2-1:0] wrIdx,
    input  logic [INST_WIDTH-1:0] wrData,
    input  logic [DEPTH_LOG2-1:0] rdIdx,
    output logic [INST_WIDTH-1:0] rdData
);

    logic [INST_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Preload write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
    end

    assign rdData = mem[rdIdx];

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-side memory responder. Accepts one fetch address at a time on
// the request channel, waits LATENCY cycles and presents the instruction word
// (or a fault) on the response channel until the core takes it.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = PcWidth,
    parameter int          INST_WIDTH = InstWidth,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] MEM_BASE   = MemBase,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [INST_WIDTH-1:0] resp_inst,
    output logic                  resp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_idx,
    input  logic [INST_WIDTH-1:0] load_data
);

    // Counter value for the first WAIT cycle; LATENCY is expected in 1..15
    localparam logic [LatCountWidth-1:0] LoadCount = latencyLoad(LATENCY);
    localparam logic [ADDR_WIDTH-1:0]    BaseAddr  = ADDR_WIDTH'(MEM_BASE);

    FetchState state;
    FetchState nextState;

    logic [LatCountWidth-1:0] latCount;
    logic [LatCountWidth-1:0] nextLatCount;
    logic                     enterResp;
    logic                     accept;

    logic [ADDR_WIDTH-1:0] addrReg;
    logic [ADDR_WIDTH-1:0] fetchAddr;
    logic [ADDR_WIDTH-1:0] byteOffset;
    logic [ADDR_WIDTH-1:0] wordOffset;
    logic [DEPTH_LOG2-1:0] fetchIdx;
    logic                  misaligned;
    logic                  belowBase;
    logic                  beyondEnd;
    logic                  fetchErr;
    logic [INST_WIDTH-1:0] readData;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With LATENCY==1 the response is formed on the accept edge itself, so the
    // live request address is used in IDLE and the captured one afterwards.
    assign fetchAddr = (state == IDLE) ? req_addr : addrReg;

    // The base guard runs first, so the subtraction below never wraps a low
    // address back into the array range.
    assign misaligned = |fetchAddr[1:0];
    assign belowBase  = fetchAddr < BaseAddr;
    assign byteOffset = fetchAddr - BaseAddr;
    assign wordOffset = byteOffset >> 2;
    assign beyondEnd  = (wordOffset >> DEPTH_LOG2) != '0;
    assign fetchIdx   = wordOffset[DEPTH_LOG2-1:0];
    assign fetchErr   = misaligned || belowBase || beyondEnd;

    inst_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INST_WIDTH (INST_WIDTH)
    ) memArray (
        .clk    (clk),
        .wrEn   (load_en),
        .wrIdx  (load_idx),
        .wrData (load_data),
        .rdIdx  (fetchIdx),
        .rdData (readData)
    );

    // State and latency counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            latCount <= '0;
        end else begin
            state    <= nextState;
            latCount <= nextLatCount;
        end
    end

    // Next-state logic: the edge on which the count would reach zero is the
    // edge that enters RESP, giving first valid LATENCY edges after accept
    always_comb begin
        nextState    = state;
        nextLatCount = latCount;
        enterResp    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextLatCount = LoadCount;
                    if (LATENCY == 1) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (latCount <= 4'd1) begin
                    nextState    = RESP;
                    nextLatCount = '0;
                    enterResp    = 1'b1;
                end else begin
                    nextLatCount = latCount - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState    = IDLE;
                nextLatCount = '0;
            end
        endcase
    end

    // Capture the fetch address on accept; the core is free to move on after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrReg <= '0;
        end else if (accept) begin
            addrReg <= req_addr;
        end
    end

    // Register the response on RESP entry and hold it until the next fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_inst <= '0;
            resp_err  <= 1'b0;
        end else if (enterResp) begin
            resp_inst <= fetchErr ? INST_WIDTH'(FaultInst) : readData;
            resp_err  <= fetchErr;
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder. Three responders with LATENCY
// 2, 1 and 15 run side by side; each has its own stimulus, reference memory,
// expectation queue and response monitor.
module tb_inst_fetch_responder;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        int          validEdge;
    } ExpItem;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gLat
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        logic        rst;
        logic        reqValid;
        logic        reqReady;
        logic [31:0] reqAddr;
        logic        respValid;
        logic        respReady;
        logic [31:0] respInst;
        logic        respErr;
        logic        loadEn;
        logic [11:0] loadIdx;
        logic [31:0] loadData;

        logic [31:0] refMem [4096];
        ExpItem      expQ[$];
        int          edgeCnt = 0;
        bit          done = 1'b0;

        inst_fetch_responder #(.LATENCY(LAT)) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (reqValid),
            .req_ready  (reqReady),
            .req_addr   (reqAddr),
            .resp_valid (respValid),
            .resp_ready (respReady),
            .resp_inst  (respInst),
            .resp_err   (respErr),
            .load_en    (loadEn),
            .load_idx   (loadIdx),
            .load_data  (loadData)
        );

        // Number of rising edges seen so far
        always @(posedge clk) edgeCnt <= edgeCnt + 1;

        task automatic checkOutput(input string name, input logic [31:0] actual,
                                   input logic [31:0] required);
            checks++;
            if (actual !== required) begin
                errors++;
                $display("[TB] FAIL %s LATENCY=%0d: got %h, expected %h", name, LAT, actual, required);
            end
        endtask

        // One fetch: the reference model decides fault/word from the memory map
        // rules, with a load at accept+loadK visible only if it lands before
        // the edge that forms the response (accept+LAT-1)
        task automatic applyStimulus(input logic [31:0] addr, input int hold, input int loadK,
                                     input logic [11:0] lIdx, input logic [31:0] lData,
                                     output int accEdge);
            ExpItem      item;
            logic [31:0] wordOff;
            bit          fault;
            bit          fin;
            int          waitCycles;
            int          validCycles;
            waitCycles = 0;
            while (!reqReady && waitCycles < 50) begin
                @(negedge clk);
                waitCycles++;
            end
            accEdge = edgeCnt + 1;
            if (!reqReady) begin
                checks++;
                errors++;
                $display("[TB] FAIL reqReadyTimeout LATENCY=%0d: got 0, expected 1", LAT);
            end else begin
                fault = (addr % 4 != 0) || (addr < 32'h80000000)
                        || ((addr - 32'h80000000) / 4 >= 4096);
                wordOff = (addr - 32'h80000000) / 4;
                item.err = fault;
                if (fault)
                    item.inst = 32'h0;
                else if (loadK >= 0 && loadK < LAT - 1 && lIdx == wordOff[11:0])
                    item.inst = lData;
                else
                    item.inst = refMem[wordOff[11:0]];
                item.validEdge = accEdge + LAT - 1;
                expQ.push_back(item);
                if (loadK >= 0) refMem[lIdx] = lData;

                reqValid = 1'b1;
                reqAddr = addr;
                validCycles = 0;
                fin = 1'b0;
                for (int j = 0; j < 60 && !fin; j++) begin
                    if (j == 1) reqValid = 1'b0;
                    loadEn = (j == loadK);
                    loadIdx = lIdx;
                    loadData = lData;
                    if (respValid) begin
                        respReady = (validCycles >= hold);
                        validCycles++;
                    end else begin
                        respReady = (hold == 0);
                    end
                    if (respValid && respReady) fin = 1'b1;
                    @(negedge clk);
                end
                loadEn = 1'b0;
                reqValid = 1'b0;
                respReady = 1'b0;
                if (!fin) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL responseTimeout LATENCY=%0d addr=%h: got no handshake, expected one", LAT, addr);
                end
            end
        endtask

        // Accept a fetch, then reset asynchronously while it waits
        task automatic resetMidWait();
            checkOutput("preResetIdle", 32'(reqReady), 32'd1);
            reqValid = 1'b1;
            reqAddr = 32'h80000010;
            respReady = 1'b1;
            @(negedge clk);
            reqValid = 1'b0;
            checkOutput("waitReqReady", 32'(reqReady), 32'd0);
            #2 rst = 1'b1;
            #1;
            checkOutput("midResetValid", 32'(respValid), 32'd0);
            checkOutput("midResetReqReady", 32'(reqReady), 32'd1);
            @(negedge clk);
            rst = 1'b0;
            repeat (LAT + 4) @(negedge clk);
            respReady = 1'b0;
        endtask

        // Response monitor: pops an expectation on each new response and
        // checks stability under backpressure and the return to idle
        initial begin : monitor
            logic        prevValid;
            logic [31:0] heldInst;
            logic        heldErr;
            ExpItem      item;
            prevValid = 1'b0;
            heldInst = 32'h0;
            heldErr = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    prevValid = 1'b0;
                end else begin
                    if (prevValid && respReady) begin
                        checkOutput("handshakeValidDrop", 32'(respValid), 32'd0);
                        checkOutput("handshakeReqReady", 32'(reqReady), 32'd1);
                        checkOutput("instHeldAfterHandshake", respInst, heldInst);
                    end else if (prevValid) begin
                        checkOutput("stallValid", 32'(respValid), 32'd1);
                        checkOutput("stallInst", respInst, heldInst);
                        checkOutput("stallErr", 32'(respErr), 32'(heldErr));
                        checkOutput("stallReqReady", 32'(reqReady), 32'd0);
                    end else if (respValid) begin
                        if (expQ.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL spuriousResponse LATENCY=%0d: got inst %h, expected no response", LAT, respInst);
                        end else begin
                            item = expQ.pop_front();
                            checkOutput("respInst", respInst, item.inst);
                            checkOutput("respErr", 32'(respErr), 32'(item.err));
                            checkOutput("respLatencyEdge", edgeCnt, item.validEdge);
                            checkOutput("respReqReady", 32'(reqReady), 32'd0);
                        end
                    end
                    prevValid = respValid;
                    heldInst = respInst;
                    heldErr = respErr;
                end
            end
        end

        // Directed and random stimulus for this latency
        initial begin : stimulus
            int acc0;
            int acc1;
            rst = 1'b1;
            reqValid = 1'b0;
            reqAddr = 32'h0;
            respReady = 1'b0;
            loadEn = 1'b0;
            loadIdx = 12'h0;
            loadData = 32'h0;
            #1;
            checkOutput("resetReqReady", 32'(reqReady), 32'd1);
            checkOutput("resetRespValid", 32'(respValid), 32'd0);
            checkOutput("resetRespInst", respInst, 32'h0);
            checkOutput("resetRespErr", 32'(respErr), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;

            for (int i = 0; i < 4096; i++) begin
                loadEn = 1'b1;
                loadIdx = 12'(i);
                loadData = (i == 0) ? 32'h00000413 : ((i == 1) ? 32'h00009117 : $urandom);
                refMem[i] = loadData;
                @(negedge clk);
            end
            loadEn = 1'b0;

            applyStimulus(32'h80000000, 0, -1, 12'h0, 32'h0, acc0);
            applyStimulus(32'h80000004, 0, -1, 12'h0, 32'h0, acc0);
            applyStimulus(32'h80000002, 0, -1, 12'h0, 32'h0, acc0);
            applyStimulus(32'h7FFFFFFC, 0, -1, 12'h0, 32'h0, acc0);
            applyStimulus(32'h80004000, 0, -1, 12'h0, 32'h0, acc0);
            applyStimulus(32'h80003FFC, 0, -1, 12'h0, 32'h0, acc0);
            applyStimulus(32'h80000008, 5, -1, 12'h0, 32'h0, acc0);

            if (LAT >= 2) applyStimulus(32'h80000014, 0, LAT - 2, 12'd5, 32'hDEADBEEF, acc0);
            applyStimulus(32'h80000014, 0, LAT - 1, 12'd5, 32'hCAFEF00D, acc0);

            applyStimulus(32'h80000020, 0, -1, 12'h0, 32'h0, acc0);
            for (int b = 0; b < 3; b++) begin
                applyStimulus(32'h80000024 + 32'(b * 4), 0, -1, 12'h0, 32'h0, acc1);
                checkOutput("throughputAcceptSpacing", acc1 - acc0, LAT + 1);
                acc0 = acc1;
            end

            if (LAT >= 2) begin
                resetMidWait();
                applyStimulus(32'h80000004, 0, -1, 12'h0, 32'h0, acc0);
            end

            for (int n = 0; n < 25; n++) begin
                logic [31:0] a;
                logic [11:0] idx;
                logic [11:0] lIdx;
                int          kind;
                int          k;
                idx = 12'($urandom_range(0, 4095));
                kind = $urandom_range(0, 9);
                case (kind)
                    0: a = 32'h80000000 + {18'b0, idx, 2'b00} + 32'($urandom_range(1, 3));
                    1: a = 32'($urandom_range(0, 32'h7FFFFFFF)) & 32'hFFFFFFFC;
                    2: a = 32'h80004000 + ($urandom & 32'h0FFFFFFC);
                    default: a = 32'h80000000 + {18'b0, idx, 2'b00};
                endcase
                k = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, LAT - 1);
                lIdx = ($urandom_range(0, 1) == 1) ? idx : 12'($urandom_range(0, 4095));
                applyStimulus(a, $urandom_range(0, 3), k, lIdx, $urandom, acc0);
            end

            repeat (LAT + 5) @(negedge clk);
            checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
            done = 1'b1;
        end
    end

    // Summary once every latency variant has finished
    initial begin
        wait (gLat[0].done && gLat[1].done && gLat[2].done);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck run still ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time limit reached, expected completion (%0d checks, %0d errors)", checks, errors);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Instruction-side memory responder that answers the core's fetch requests.
- The core presents a PC on a valid/ready request channel. This block returns the 32-bit instruction word on a valid/ready response channel after a fixed, parameterised latency.
- It owns the instruction storage array. A preload write port lets the bench or loader fill the array.
- It replaces the direct combinational `inst` hookup at the top level. It is the memory end of the PC-out / instruction-in interface.

Parameters:
- ADDR_WIDTH, 32, width of fetch address (matches PC width).
- INST_WIDTH, 32, width of instruction word.
- DEPTH_LOG2, 12, log2 of word count in the array (4096 words).
- MEM_BASE, 32'h80000000, byte address of word 0.
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a fetch address.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  byte address of the fetch (next_pc).
- resp_valid  out  1  response word is available.
- resp_ready  in  1  core consumes the response.
- resp_inst  out  INST_WIDTH  fetched instruction word.
- resp_err  out  1  fetch fault (misaligned or out of range).
- load_en  in  1  preload write strobe.
- load_idx  in  DEPTH_LOG2  word index to preload.
- load_data  in  INST_WIDTH  preload data.

Behaviour:
- Reset (asynchronous assert):
  - state=IDLE, req_ready=1, resp_valid=0, resp_inst=0, resp_err=0, latency counter=0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP. At most one request outstanding.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge N: capture req_addr and set counter=LATENCY-1.
  - If LATENCY==1, go to RESP at edge N+1. Otherwise go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter reaches 0, the next edge moves to RESP.
- Latency: resp_valid is first high in the cycle following edge N+LATENCY-1, i.e. valid at edge N+LATENCY.
- Response data and fault are registered on entry to RESP:
  - Fault check: err=1 if addr[1:0]!=0, or addr<MEM_BASE, or (addr-MEM_BASE)>>2 >= 2**DEPTH_LOG2.
  - If err: resp_inst=0, resp_err=1.
  - Otherwise: resp_inst=mem[(addr-MEM_BASE)>>2], resp_err=0.
- RESP:
  - resp_valid=1; resp_inst and resp_err held stable while resp_ready=0.
  - req_ready=0.
  - On resp_valid && resp_ready: go to IDLE, clear resp_valid, hold resp_inst (no clear).
- Throughput: one fetch per LATENCY+1 cycles with resp_ready held high.
- Preload:
  - load_en writes mem[load_idx]=load_data at the edge, in any state.
  - A load to the same index at the same edge as RESP entry returns the old word (read-before-write).
  - A load at an earlier edge during WAIT is visible in the response.
- req_valid while req_ready=0 is ignored. The core must hold the request; the responder does not latch it.
- Address arithmetic is unsigned and ADDR_WIDTH-wide; the subtraction does not wrap into range because of the addr<MEM_BASE guard.
- Reset mid-operation: the outstanding request is discarded, no response is produced, and req_ready=1 immediately.

Decomposition:
- Shared defines (existing include file) hold:
  - InstWidth and the PC/ImmWidth constants.
  - New MemBase constant (32'h80000000).
  - State encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Fault-inst value 32'h0.
- One sub-module, inst_mem_array:
  - 1 synchronous write port, 1 read port, parameterised by DEPTH_LOG2 and INST_WIDTH.
  - Registered read is performed by the parent on RESP entry.
- FSM, counter and fault check stay in inst_fetch_responder.

Test Plan:
- Basic fetch:
  - Stimulus: preload idx0=32'h00000413, idx1=32'h00009117; LATENCY=2; request 0x80000000 at edge 10 with resp_ready=1.
  - Required response: resp_valid at edge 12, resp_inst=32'h00000413, err=0, back in IDLE after edge 13.
  - Then request 0x80000004 → resp_inst=32'h00009117.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid.
  - Required response: resp_inst stable, req_ready=0 throughout; handshake on the 6th cycle returns to IDLE.
- Faults:
  - 0x80000002 → resp_err=1, resp_inst=0.
  - 0x7FFFFFFC → resp_err=1.
  - 0x80004000 (first index beyond DEPTH_LOG2=12) → resp_err=1.
  - 0x80003FFC → err=0, returns mem[4095].
- Latency sweep:
  - Stimulus: LATENCY=1 and LATENCY=15.
  - Required response: resp_valid exactly 1 and 15 edges after accept; throughput 1 per 2 and 1 per 16 cycles.
- Preload collision:
  - Stimulus: load idx5=32'hDEADBEEF during WAIT of a fetch to 0x80000014.
  - Required response: returns 32'hDEADBEEF.
  - Repeat with the load at the RESP-entry edge → the old value is returned.
- Reset mid-WAIT:
  - Stimulus: assert rst asynchronously between edges during WAIT.
  - Required response: resp_valid=0 and req_ready=1 immediately; no spurious response after release; a new request is served normally.
